hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage RV32 core. Each cycle it decides which stage registers hold (stall) and which are cleared to bubbles (flush). The decision covers load-use hazards, taken branches/jumps resolved in EX, multi-cycle instruction fetch and multi-cycle data-memory access. It also produces the EX-stage forwarding selects. Its StallD/FlushD drive the IF/ID register as En = ~StallD, clr = FlushD; the other outputs drive the PC register and the ID/EX, EX/MEM and MEM/WB registers in the same way.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/fwd_unit.sv | 25 ++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// fetch-sequencing FSM states.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // F_KILL: the fetch still in flight belongs to a squashed path.
  typedef enum logic {
    F_RUN  = 1'b0,
    F_KILL = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select for one source operand.
// The MEM-stage producer is younger than WB, so it wins when both match.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rd_m,
  input  logic [RW-1:0] rd_w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output fwd_sel_e      sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / sequencing controller for the five-stage RV32 core.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RW     = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RW-1:0]     Rs1D,
  input  logic [RW-1:0]     Rs2D,
  input  logic [RW-1:0]     Rs1E,
  input  logic [RW-1:0]     Rs2E,
  input  logic [RW-1:0]     RdE,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic [RW-1:0]     RdM,
  input  logic [RW-1:0]     RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ImemRdyF,
  input  logic              DmemReqM,
  input  logic              DmemRdyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] FlushCnt
);

  fetch_state_e state;
  fwd_sel_e     fwd_a;
  fwd_sel_e     fwd_b;

  logic data_stall;
  logic redirect;
  logic load_use;
  logic fetch_wait;

  assign data_stall = DmemReqM && !DmemRdyM;
  assign redirect   = PCSrcE && !data_stall && !rst;
  assign load_use   = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign fetch_wait = (state == F_KILL) || !ImemRdyF;

  fwd_unit #(.RW(RW)) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  fwd_unit #(.RW(RW)) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  // Priority: reset, data stall, redirect, load-use, fetch wait.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    if (rst) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end else if (data_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (fetch_wait) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  // A redirect with the old fetch still outstanding must drop its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_RUN;
    end else if (redirect) begin
      state <= ImemRdyF ? F_RUN : F_KILL;
    end else if ((state == F_KILL) && ImemRdyF) begin
      state <= F_RUN;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + 1'b1;
      if (redirect && (FlushCnt != '1)) FlushCnt <= FlushCnt + 1'b1;
    end
  end
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; counter expectations follow PIPE_CTRL_PERF_EN.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int RW     = 5;
  localparam int PERF_W = 32;

  logic              clk;
  logic              rst;
  logic [RW-1:0]     Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              LoadE, PCSrcE, RegWriteM, RegWriteW;
  logic              ImemRdyF, DmemReqM, DmemRdyM;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [PERF_W-1:0] StallCnt, FlushCnt;

  int checks;
  int failures;
  logic [PERF_W-1:0] exp_stall;
  logic [PERF_W-1:0] exp_flush;

  hazard_ctrl #(.RW(RW), .PERF_W(PERF_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .LoadE     (LoadE),
    .PCSrcE    (PCSrcE),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ImemRdyF  (ImemRdyF),
    .DmemReqM  (DmemReqM),
    .DmemRdyM  (DmemRdyM),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
  endtask

  task automatic chk_state(input string tag, input fetch_state_e exp);
    chk(tag, {31'd0, dut.state}, {31'd0, exp});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stall_cnt"}, StallCnt, exp_stall);
    chk({tag, "_flush_cnt"}, FlushCnt, exp_flush);
  endtask

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    LoadE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ImemRdyF = 1'b1; DmemReqM = 1'b0; DmemRdyM = 1'b0;
  endtask

  // s: StallF expected high this cycle; f: redirect expected to fire.
  task automatic tick(input bit s, input bit f);
`ifdef PIPE_CTRL_PERF_EN
    exp_stall = exp_stall + PERF_W'(s);
    exp_flush = exp_flush + PERF_W'(f);
`else
    if (s || f) begin end
`endif
    @(posedge clk);
    #1;
  endtask

  // control vector order: StallF StallD StallE StallM FlushD FlushE FlushW
  initial begin
    checks = 0;
    failures = 0;
    exp_stall = '0;
    exp_flush = '0;
    idle();
    rst = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd4; Rs1E = 5'd4;
    #1;
    chk_ctl("reset_ctl", 7'b0000111);
    chk("reset_fwd_a", {30'd0, ForwardAE}, 32'd0);
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;
    idle();
    #1;
    chk_state("post_reset_state", F_RUN);
    chk_cnt("post_reset");
    chk_ctl("idle_ctl", 7'b0000000);

    // load-use via Rs1D
    LoadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    #1;
    chk_ctl("load_use_ctl", 7'b1100010);
    tick(1, 0);
    idle();
    Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1;
    #1;
    chk_ctl("after_load_use_ctl", 7'b0000000);
    chk("after_load_use_fwd_a", {30'd0, ForwardAE}, 32'h1);
    tick(0, 0);
    chk_cnt("load_use");

    // load to x0 is never a hazard
    idle();
    LoadE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
    #1;
    chk_ctl("load_x0_ctl", 7'b0000000);
    tick(0, 0);
    RdE = 5'd9; Rs2D = 5'd9;
    #1;
    chk_ctl("load_use_rs2_ctl", 7'b1100010);
    tick(1, 0);

    // redirect with fetch ready
    idle();
    PCSrcE = 1'b1;
    #1;
    chk_ctl("redirect_rdy_ctl", 7'b0000110);
    tick(0, 1);
    chk_state("redirect_rdy_state", F_RUN);
    chk_cnt("redirect_rdy");

    // redirect during fetch wait, then 3 kill cycles
    idle();
    ImemRdyF = 1'b0; PCSrcE = 1'b1;
    #1;
    chk_ctl("redirect_wait_ctl", 7'b0000110);
    tick(0, 1);
    chk_state("kill_enter_state", F_KILL);
    PCSrcE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_ctl("kill_wait_ctl", 7'b1000100);
      tick(1, 0);
      chk_state("kill_hold_state", F_KILL);
    end
    ImemRdyF = 1'b1;
    #1;
    chk_ctl("kill_drop_ctl", 7'b1000100);
    tick(1, 0);
    chk_state("kill_exit_state", F_RUN);
    chk_ctl("kill_exit_ctl", 7'b0000000);
    tick(0, 0);
    chk_cnt("kill");

    // back-to-back redirect while in F_KILL
    idle();
    ImemRdyF = 1'b0; PCSrcE = 1'b1;
    tick(0, 1);
    #1;
    chk_ctl("b2b_ctl", 7'b0000110);
    tick(0, 1);
    chk_state("b2b_state", F_KILL);
    PCSrcE = 1'b0; ImemRdyF = 1'b1;
    tick(1, 0);
    chk_state("b2b_exit_state", F_RUN);

    // dmem stall with pending redirect and load-use hazard
    idle();
    DmemReqM = 1'b1; DmemRdyM = 1'b0; PCSrcE = 1'b1;
    LoadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl("dmem_stall_ctl", 7'b1111001);
      tick(1, 0);
    end
    DmemRdyM = 1'b1;
    #1;
    chk_ctl("dmem_release_ctl", 7'b0000110);
    tick(0, 1);
    chk_cnt("dmem");

    // dmem stall consumes the stale fetch in F_KILL
    idle();
    PCSrcE = 1'b1; ImemRdyF = 1'b0;
    tick(0, 1);
    PCSrcE = 1'b0; ImemRdyF = 1'b1; DmemReqM = 1'b1; DmemRdyM = 1'b0;
    #1;
    chk_ctl("dmem_kill_ctl", 7'b1111001);
    tick(1, 0);
    chk_state("dmem_kill_state", F_RUN);
    DmemReqM = 1'b0;
    #1;
    chk_ctl("dmem_kill_after_ctl", 7'b0000000);

    // forwarding priority
    idle();
    RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs2E = 5'd7;
    #1;
    chk("fwd_b_mem", {30'd0, ForwardBE}, 32'h2);
    chk("fwd_a_none", {30'd0, ForwardAE}, 32'h0);
    RdM = 5'd0;
    #1;
    chk("fwd_b_rdm_x0", {30'd0, ForwardBE}, 32'h1);
    RdM = 5'd7; RegWriteM = 1'b0;
    #1;
    chk("fwd_b_wb", {30'd0, ForwardBE}, 32'h1);
    RegWriteW = 1'b0;
    #1;
    chk("fwd_b_rf", {30'd0, ForwardBE}, 32'h0);
    RegWriteM = 1'b1; Rs1E = 5'd7;
    #1;
    chk("fwd_a_mem", {30'd0, ForwardAE}, 32'h2);

    // reset during forwarding and mid-kill
    RegWriteW = 1'b1; Rs1E = 5'd0;
    PCSrcE = 1'b1; ImemRdyF = 1'b0;
    tick(0, 1);
    chk_state("pre_reset_state", F_KILL);
    PCSrcE = 1'b0;
    rst = 1'b1;
    #1;
    chk_ctl("mid_reset_ctl", 7'b0000111);
    chk("mid_reset_fwd_b", {30'd0, ForwardBE}, 32'h0);
    tick(0, 0);
    exp_stall = '0;
    exp_flush = '0;
    chk_state("reset_clears_kill", F_RUN);
    chk_cnt("reset");
    rst = 1'b0; ImemRdyF = 1'b1;
    #1;
    chk_ctl("after_reset_ctl", 7'b0000000);
    chk("after_reset_fwd_b", {30'd0, ForwardBE}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
